// File: rtl/gb_cpu_interrupt_ctrl.sv
// rtl/gb_cpu_interrupt_ctrl.sv - Game Boy CPU IME, HALT and interrupt dispatch sequencer
module gb_cpu_interrupt_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] ie,
   input  logic [4:0] if_flags,
   input  logic       last_m_cycle,
   input  logic       ei_cmd,
   input  logic       di_cmd,
   input  logic       reti_cmd,
   input  logic       halt_cmd,
   output logic       ime,
   output logic       interrupt_queued,
   output logic       interrupt_queued_no_IME,
   output logic       halt,
   output logic       halt_bug_delay,
   output logic       dispatch_active,
   output logic       sp_dec,
   output logic       push_pc_hi,
   output logic       push_pc_lo,
   output logic       write_interrupt_vector,
   output logic [7:0] interrupt_vector,
   output logic [4:0] if_ack
);

   typedef enum logic [2:0] {
      S_RUN, S_HALTED, S_D1, S_D2, S_D3, S_D4, S_D5
   } state_t;

   state_t     state, state_nxt;
   logic       ei_pending, ime_nxt, ei_pending_nxt, bug_nxt;
   logic [4:0] pend, ack_sel;
   logic [7:0] vec_sel;
   logic       any_pend;

   assign pend                    = ie & if_flags;
   assign any_pend                = |pend;
   assign interrupt_queued        = ime & any_pend;
   assign interrupt_queued_no_IME = ~ime & any_pend;

   // Bit 0 (VBlank) wins; an empty pending set yields vector 00 and no ack.
   always_comb begin
      vec_sel = 8'h00;
      ack_sel = 5'h00;
      if (pend[0]) begin
         vec_sel = 8'h40; ack_sel = 5'h01;
      end else if (pend[1]) begin
         vec_sel = 8'h48; ack_sel = 5'h02;
      end else if (pend[2]) begin
         vec_sel = 8'h50; ack_sel = 5'h04;
      end else if (pend[3]) begin
         vec_sel = 8'h58; ack_sel = 5'h08;
      end else if (pend[4]) begin
         vec_sel = 8'h60; ack_sel = 5'h10;
      end
   end

   always_comb begin
      state_nxt      = state;
      ime_nxt        = ime;
      ei_pending_nxt = ei_pending;
      bug_nxt        = 1'b0;
      case (state)
         S_RUN: begin
            if (last_m_cycle) begin
               if (interrupt_queued) begin
                  state_nxt = S_D1;
               end else begin
                  // Promotion of an earlier EI comes first so a DI in the same slot still wins.
                  if (ei_pending) begin
                     ime_nxt        = 1'b1;
                     ei_pending_nxt = 1'b0;
                  end
                  if (ei_cmd)   ei_pending_nxt = 1'b1;
                  if (reti_cmd) ime_nxt        = 1'b1;
                  if (di_cmd) begin
                     ime_nxt        = 1'b0;
                     ei_pending_nxt = 1'b0;
                  end
                  if (halt_cmd) begin
                     if (ime || !any_pend) state_nxt = S_HALTED;
                     else                  bug_nxt   = 1'b1;
                  end
               end
            end
         end
         S_HALTED: begin
            if (any_pend) state_nxt = ime ? S_D1 : S_RUN;
         end
         S_D1: begin
            ime_nxt        = 1'b0;
            ei_pending_nxt = 1'b0;
            state_nxt      = S_D2;
         end
         S_D2:    state_nxt = S_D3;
         S_D3:    state_nxt = S_D4;
         S_D4:    state_nxt = S_D5;
         S_D5:    state_nxt = S_RUN;
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= S_RUN;
         ime                    <= 1'b0;
         ei_pending             <= 1'b0;
         halt                   <= 1'b0;
         halt_bug_delay         <= 1'b0;
         dispatch_active        <= 1'b0;
         sp_dec                 <= 1'b0;
         push_pc_hi             <= 1'b0;
         push_pc_lo             <= 1'b0;
         write_interrupt_vector <= 1'b0;
         interrupt_vector       <= 8'h00;
         if_ack                 <= 5'h00;
      end else begin
         state                  <= state_nxt;
         ime                    <= ime_nxt;
         ei_pending             <= ei_pending_nxt;
         halt                   <= (state_nxt == S_HALTED);
         halt_bug_delay         <= bug_nxt;
         dispatch_active        <= (state_nxt != S_RUN) && (state_nxt != S_HALTED);
         sp_dec                 <= (state_nxt == S_D2);
         push_pc_hi             <= (state_nxt == S_D3);
         push_pc_lo             <= (state_nxt == S_D4);
         write_interrupt_vector <= (state_nxt == S_D5);
         // Pending set is sampled on the D3->D4 edge so a late IE/IF change can cancel.
         if (state_nxt == S_D4) begin
            interrupt_vector <= vec_sel;
            if_ack           <= ack_sel;
         end else begin
            if_ack           <= 5'h00;
         end
      end
   end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// tb/tb_gb_cpu_interrupt_ctrl.sv - self-checking bench for gb_cpu_interrupt_ctrl
module tb_gb_cpu_interrupt_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] ie = 5'h00, if_flags = 5'h00;
   logic       last_m_cycle = 1'b0, ei_cmd = 1'b0, di_cmd = 1'b0, reti_cmd = 1'b0, halt_cmd = 1'b0;
   logic       ime, interrupt_queued, interrupt_queued_no_IME, halt, halt_bug_delay;
   logic       dispatch_active, sp_dec, push_pc_hi, push_pc_lo, write_interrupt_vector;
   logic [7:0] interrupt_vector;
   logic [4:0] if_ack;

   int n_checks = 0;
   int n_fail   = 0;

   gb_cpu_interrupt_ctrl dut (
      .clk(clk), .reset(reset), .ie(ie), .if_flags(if_flags),
      .last_m_cycle(last_m_cycle), .ei_cmd(ei_cmd), .di_cmd(di_cmd),
      .reti_cmd(reti_cmd), .halt_cmd(halt_cmd), .ime(ime),
      .interrupt_queued(interrupt_queued), .interrupt_queued_no_IME(interrupt_queued_no_IME),
      .halt(halt), .halt_bug_delay(halt_bug_delay), .dispatch_active(dispatch_active),
      .sp_dec(sp_dec), .push_pc_hi(push_pc_hi), .push_pc_lo(push_pc_lo),
      .write_interrupt_vector(write_interrupt_vector),
      .interrupt_vector(interrupt_vector), .if_ack(if_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = not dispatching, 1..5 = dispatch cycle number.
   bit       m_ime, m_eip, m_halted, m_bug;
   int       m_phase;
   bit [7:0] m_vec;
   bit [4:0] m_ack;

   always @(posedge clk) begin
      bit [4:0] p;
      bit       nime, neip;
      p = ie & if_flags;
      if (reset) begin
         m_ime = 0; m_eip = 0; m_halted = 0; m_bug = 0; m_phase = 0; m_vec = 0; m_ack = 0;
      end else begin
         m_ack = 0;
         m_bug = 0;
         if (m_phase != 0) begin
            if (m_phase == 1) begin m_ime = 0; m_eip = 0; end
            if (m_phase == 3) begin
               m_vec = 8'h00;
               for (int i = 4; i >= 0; i--)
                  if (p[i]) begin m_vec = 8'(8'h40 + 8 * i); m_ack = 5'(1 << i); end
            end
            m_phase = (m_phase == 5) ? 0 : m_phase + 1;
         end else if (m_halted) begin
            if (p != 0) begin
               m_halted = 0;
               if (m_ime) m_phase = 1;
            end
         end else if (last_m_cycle) begin
            if (m_ime && p != 0) begin
               m_phase = 1;
            end else begin
               nime = m_ime; neip = m_eip;
               if (m_eip)    begin nime = 1; neip = 0; end
               if (ei_cmd)   neip = 1;
               if (reti_cmd) nime = 1;
               if (di_cmd)   begin nime = 0; neip = 0; end
               if (halt_cmd) begin
                  if (m_ime || p == 0) m_halted = 1;
                  else                 m_bug = 1;
               end
               m_ime = nime; m_eip = neip;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit anyp;
      anyp = |(ie & if_flags);
      check("ime", 8'(ime), 8'(m_ime));
      check("interrupt_queued", 8'(interrupt_queued), 8'(m_ime & anyp));
      check("interrupt_queued_no_IME", 8'(interrupt_queued_no_IME), 8'(!m_ime & anyp));
      check("queued_exclusive", 8'(interrupt_queued & interrupt_queued_no_IME), 8'h00);
      check("halt", 8'(halt), 8'(m_halted));
      check("halt_bug_delay", 8'(halt_bug_delay), 8'(m_bug));
      check("dispatch_active", 8'(dispatch_active), 8'(m_phase != 0));
      check("sp_dec", 8'(sp_dec), 8'(m_phase == 2));
      check("push_pc_hi", 8'(push_pc_hi), 8'(m_phase == 3));
      check("push_pc_lo", 8'(push_pc_lo), 8'(m_phase == 4));
      check("write_interrupt_vector", 8'(write_interrupt_vector), 8'(m_phase == 5));
      check("interrupt_vector", interrupt_vector, m_vec);
      check("if_ack", 8'(if_ack), 8'(m_ack));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [4:0] e, input logic [4:0] f, input logic l,
                        input logic ei, input logic di, input logic rt, input logic h);
      ie = e; if_flags = f; last_m_cycle = l;
      ei_cmd = ei; di_cmd = di; reti_cmd = rt; halt_cmd = h;
   endtask

   task automatic set_ime();
      drive(5'h00, 5'h00, 1, 0, 0, 1, 0);
      tick();
      check("d_reti_ime", 8'(ime), 8'h01);
   endtask

   initial begin
      repeat (2) tick();
      reset = 1'b0;
      check("d_reset_ime", 8'(ime), 8'h00);
      check("d_reset_vec", interrupt_vector, 8'h00);
      check("d_reset_disp", 8'(dispatch_active), 8'h00);

      // Timer dispatch: full D1..D5 walk.
      set_ime();
      drive(5'h04, 5'h04, 1, 0, 0, 0, 0);
      tick();
      last_m_cycle = 0;
      check("d1_disp", 8'(dispatch_active), 8'h01);
      tick();
      check("d2_sp_dec", 8'(sp_dec), 8'h01);
      check("d2_ime", 8'(ime), 8'h00);
      tick();
      check("d3_push_hi", 8'(push_pc_hi), 8'h01);
      tick();
      check("d4_push_lo", 8'(push_pc_lo), 8'h01);
      check("d4_if_ack", 8'(if_ack), 8'h04);
      tick();
      check("d5_wiv", 8'(write_interrupt_vector), 8'h01);
      check("d5_vec", interrupt_vector, 8'h50);
      check("d5_ack_clr", 8'(if_ack), 8'h00);
      tick();
      check("d_end_disp", 8'(dispatch_active), 8'h00);

      // Priority: all pending -> VBlank, then STAT after clearing bit 0.
      drive(5'h1F, 5'h1F, 1, 0, 0, 1, 0);
      tick();
      drive(5'h1F, 5'h1F, 1, 0, 0, 0, 0);
      tick();
      last_m_cycle = 0;
      repeat (3) tick();
      check("prio_vec40", interrupt_vector, 8'h40);
      check("prio_ack01", 8'(if_ack), 8'h01);
      repeat (2) tick();
      drive(5'h1F, 5'h1E, 1, 0, 0, 1, 0);
      tick();
      drive(5'h1F, 5'h1E, 1, 0, 0, 0, 0);
      tick();
      last_m_cycle = 0;
      repeat (3) tick();
      check("prio_vec48", interrupt_vector, 8'h48);
      check("prio_ack02", 8'(if_ack), 8'h02);
      repeat (2) tick();

      // EI delay with a pending interrupt.
      drive(5'h01, 5'h01, 1, 1, 0, 0, 0);
      tick();
      check("ei_no_disp", 8'(dispatch_active), 8'h00);
      check("ei_ime0", 8'(ime), 8'h00);
      drive(5'h01, 5'h01, 1, 0, 0, 0, 0);
      tick();
      check("ei_ime1", 8'(ime), 8'h01);
      check("ei_still_no_disp", 8'(dispatch_active), 8'h00);
      tick();
      check("ei_then_disp", 8'(dispatch_active), 8'h01);
      last_m_cycle = 0;
      repeat (5) tick();
      drive(5'h00, 5'h00, 1, 1, 0, 0, 0);
      tick();
      drive(5'h00, 5'h00, 1, 0, 1, 0, 0);
      tick();
      drive(5'h00, 5'h00, 1, 0, 0, 0, 0);
      tick();
      check("ei_di_ime0", 8'(ime), 8'h00);

      // HALT with ime = 1, woken by Joypad.
      set_ime();
      drive(5'h00, 5'h00, 1, 0, 0, 0, 1);
      tick();
      check("halt_set", 8'(halt), 8'h01);
      drive(5'h00, 5'h00, 0, 0, 0, 0, 0);
      tick();
      check("halt_hold", 8'(halt), 8'h01);
      drive(5'h10, 5'h10, 0, 0, 0, 0, 0);
      tick();
      check("halt_wake", 8'(halt), 8'h00);
      check("halt_wake_disp", 8'(dispatch_active), 8'h01);
      repeat (3) tick();
      check("halt_vec60", interrupt_vector, 8'h60);
      repeat (2) tick();

      // HALT bug, then HALTED with ime = 0 exiting without dispatch.
      drive(5'h01, 5'h01, 1, 0, 0, 0, 1);
      tick();
      check("bug_halt0", 8'(halt), 8'h00);
      check("bug_pulse", 8'(halt_bug_delay), 8'h01);
      drive(5'h01, 5'h01, 0, 0, 0, 0, 0);
      tick();
      check("bug_pulse_end", 8'(halt_bug_delay), 8'h00);
      drive(5'h00, 5'h01, 1, 0, 0, 0, 1);
      tick();
      check("halt_noime", 8'(halt), 8'h01);
      drive(5'h01, 5'h01, 0, 0, 0, 0, 0);
      tick();
      check("halt_noime_exit", 8'(halt), 8'h00);
      check("halt_noime_nodisp", 8'(dispatch_active), 8'h00);
      tick();

      // Cancelled dispatch: IE cleared during D3.
      set_ime();
      drive(5'h02, 5'h02, 1, 0, 0, 0, 0);
      tick();
      last_m_cycle = 0;
      repeat (2) tick();
      ie = 5'h00;
      tick();
      check("cancel_vec", interrupt_vector, 8'h00);
      check("cancel_ack", 8'(if_ack), 8'h00);
      check("cancel_push_lo", 8'(push_pc_lo), 8'h01);
      repeat (2) tick();

      // Reset during D2.
      set_ime();
      drive(5'h01, 5'h01, 1, 0, 0, 0, 0);
      tick();
      last_m_cycle = 0;
      tick();
      check("rst_pre_sp_dec", 8'(sp_dec), 8'h01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_ime", 8'(ime), 8'h00);
      check("rst_disp", 8'(dispatch_active), 8'h00);
      check("rst_push_hi", 8'(push_pc_hi), 8'h00);
      check("rst_vec", interrupt_vector, 8'h00);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         int c;
         c = $urandom_range(0, 9);
         drive(5'($urandom), 5'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)),
               c == 0, c == 1, c == 2, c == 3);
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      drive(5'h00, 5'h00, 0, 0, 0, 0, 0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
